// File: rtl/fp_mul_sched_pkg.sv
// fp_mul_sched_pkg: binary32 constants, classification helpers and result flags.
package fp_mul_sched_pkg;
  localparam int FP_BIAS = 127;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_flags_t;
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] == 23'd0);
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction
endpackage

// File: rtl/fp_mul_sched_if.sv
// fp_mul_sched_if: two operand request ports and the tagged result port.
interface fp_mul_sched_if;
  logic req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic res_valid, res_ready, res_id;
  logic [31:0] res_data;
  fp_mul_sched_pkg::fp_flags_t res_flags;
  modport slave(
    input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id, res_flags
  );
  modport master(
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input req0_ready, req1_ready, res_valid, res_data, res_id, res_flags
  );
endinterface

// File: rtl/fp_mul_sched_mantisma_approx.sv
// mantisma_approx: shared 24x24 significand multiplier, normalised and rounded to 23 bits.
module mantisma_approx (
  input  logic [30:0] a_i,
  input  logic [30:0] b_i,
  output logic [22:0] product_mantissa_o,
  output logic        normalised_o
);
  logic [25:0] p;
  always_comb begin
    p = 26'((48'({a_i[30:23] != 8'd0, a_i[22:0]}) * 48'({b_i[30:23] != 8'd0, b_i[22:0]})) >> 22);
    normalised_o = p[25];
    product_mantissa_o = p[25] ? p[24:2] + 23'(p[1]) : p[23:1] + 23'(p[0]);
  end
endmodule

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin two-port FP32 multiply scheduler with a two-stage backpressured pipeline.
module fp_mul_sched
  import fp_mul_sched_pkg::*;
(
  input logic clk,
  input logic reset,
  fp_mul_sched_if.slave bus
);
  logic rr_q, rr_d, s1_valid_q, s1_valid_d, s1_id_q, s1_id_d;
  logic [31:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic res_valid_q, res_valid_d, res_id_q, res_id_d;
  logic [31:0] res_data_q, res_data_d;
  fp_flags_t res_flags_q, res_flags_d;
  logic g0, g1, s1_load, s2_load, acc0, acc1, sgn, norm;
  logic [7:0] ea, eb;
  logic [22:0] mant;
  logic signed [9:0] e;
  logic [31:0] prod;
  fp_flags_t flags;

  mantisma_approx u_mant (
    .a_i(s1_a_q[30:0]),
    .b_i(s1_b_q[30:0]),
    .product_mantissa_o(mant),
    .normalised_o(norm)
  );

  assign g0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
  assign g1 = bus.req1_valid && (!bus.req0_valid || rr_q);
  assign s2_load = s1_valid_q && (!res_valid_q || bus.res_ready);
  assign s1_load = !s1_valid_q || s2_load;
  assign bus.req0_ready = g0 && s1_load && !reset;
  assign bus.req1_ready = g1 && s1_load && !reset;
  assign acc0 = bus.req0_valid && bus.req0_ready;
  assign acc1 = bus.req1_valid && bus.req1_ready;

  always_comb begin
    rr_d = (acc0 || acc1) ? !rr_q : rr_q;
    s1_valid_d = s1_load ? (acc0 || acc1) : s1_valid_q;
    s1_a_d = !(acc0 || acc1) ? s1_a_q : acc1 ? bus.req1_a : bus.req0_a;
    s1_b_d = !(acc0 || acc1) ? s1_b_q : acc1 ? bus.req1_b : bus.req0_b;
    s1_id_d = (acc0 || acc1) ? acc1 : s1_id_q;
  end

  // Subnormal inputs use exponent 1 with no hidden bit; mantissa rounding carry is not folded back.
  always_comb begin
    sgn = s1_a_q[31] ^ s1_b_q[31];
    ea = (s1_a_q[30:23] == 8'd0) ? 8'd1 : s1_a_q[30:23];
    eb = (s1_b_q[30:23] == 8'd0) ? 8'd1 : s1_b_q[30:23];
    e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(FP_BIAS)) + $signed({9'd0, norm});
    flags = '0;
    prod = {sgn, e[7:0], mant};
    if (is_nan(s1_a_q) || is_nan(s1_b_q) || (is_inf(s1_a_q) && is_zero(s1_b_q)) ||
        (is_zero(s1_a_q) && is_inf(s1_b_q))) begin
      prod = FP_QNAN;
      flags.invalid = 1'b1;
    end else if (is_inf(s1_a_q) || is_inf(s1_b_q)) begin
      prod = {sgn, FP_EXP_MAX, 23'd0};
    end else if (is_zero(s1_a_q) || is_zero(s1_b_q)) begin
      prod = {sgn, 31'd0};
    end else if (e > 10'sd254) begin
      prod = {sgn, FP_EXP_MAX, 23'd0};
      flags.overflow = 1'b1;
    end else if (e < 10'sd1) begin
      prod = {sgn, 31'd0};
      flags.underflow = 1'b1;
    end
  end

  always_comb begin
    res_valid_d = s2_load || (res_valid_q && !bus.res_ready);
    res_data_d = s2_load ? prod : res_data_q;
    res_flags_d = s2_load ? flags : res_flags_q;
    res_id_d = s2_load ? s1_id_q : res_id_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_flags_q <= '0;
      res_id_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q <= s1_id_d;
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_flags_q <= res_flags_d;
      res_id_q <= res_id_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_id = res_id_q;
endmodule

// File: tb/tb_fp_mul_sched.sv
// tb_fp_mul_sched: randomized scoreboard bench for fp_mul_sched against an arithmetic FP32 model.
module tb_fp_mul_sched;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  fp_mul_sched_if bus();
  fp_mul_sched dut(.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0, n_err = 0;
  logic [35:0] sb[$];
  logic [1:0] did = 2'b00;
  logic tb_rr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 1 : 2;
    return (x[30:0] == 31'd0) ? 0 : 3;
  endfunction

  // Expected {id, flags, data} from IEEE-style arithmetic on the operand fields.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic id);
    logic s, n;
    int ea, eb, e, ca, cb;
    logic [47:0] p;
    logic [22:0] m;
    logic [2:0] f;
    logic [31:0] d;
    s = a[31] ^ b[31];
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    p = 48'({a[30:23] != 8'd0, a[22:0]}) * 48'({b[30:23] != 8'd0, b[22:0]});
    n = p[47];
    m = n ? p[46:24] + 23'(p[23]) : p[45:23] + 23'(p[22]);
    e = ea + eb - 127 + int'(n);
    ca = cls(a);
    cb = cls(b);
    f = 3'b000;
    if (ca == 2 || cb == 2 || (ca == 1 && cb == 0) || (ca == 0 && cb == 1)) begin
      d = 32'h7FC00000; f = 3'b100;
    end else if (ca == 1 || cb == 1) d = {s, 8'hFF, 23'd0};
    else if (ca == 0 || cb == 0) d = {s, 31'd0};
    else if (e >= 255) begin d = {s, 8'hFF, 23'd0}; f = 3'b010; end
    else if (e <= 0) begin d = {s, 31'd0}; f = 3'b001; end
    else d = {s, 8'(e), m};
    return {id, f, d};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] sp [10] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                             32'h7F800001, 32'h00800000, 32'h7F000000, 32'h00000123, 32'h00400000};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 9)];
    return {1'($urandom), 8'($urandom_range(60, 195)), 23'($urandom)};
  endfunction

  task automatic set_port(input int p, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; end
    else begin bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; end
  endtask

  function automatic logic get_v(input int p);
    return (p == 0) ? bus.req0_valid : bus.req1_valid;
  endfunction

  // Monitor: checks arbitration/ready against an occupancy model, scores results, checks stall holds.
  initial begin
    logic hold = 1'b0, rv, acc, g0, g1, s1occ;
    logic [44:0] hold_val = '0;
    int n;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete(); tb_rr = 1'b0; did = 2'b00; hold = 1'b0;
      end else begin
        n = sb.size();
        rv = bus.res_valid;
        if (hold) chk("stall hold", {rv, bus.res_id, bus.res_flags, bus.res_data}, {8'd0, hold_val});
        s1occ = (n - int'(rv)) > 0;
        acc = !s1occ || !rv || bus.res_ready;
        g0 = bus.req0_valid && (!bus.req1_valid || !tb_rr);
        g1 = bus.req1_valid && (!bus.req0_valid || tb_rr);
        chk("ready0", bus.req0_ready, g0 && acc);
        chk("ready1", bus.req1_ready, g1 && acc);
        if (rv && bus.res_ready) begin
          if (n == 0) chk("unexpected result", {bus.res_id, bus.res_flags, bus.res_data}, 64'hDEAD);
          else chk("result", {bus.res_id, bus.res_flags, bus.res_data}, sb.pop_front());
        end
        did = {bus.req1_valid && bus.req1_ready, bus.req0_valid && bus.req0_ready};
        if (did[0]) sb.push_back(model(bus.req0_a, bus.req0_b, 1'b0));
        if (did[1]) sb.push_back(model(bus.req1_a, bus.req1_b, 1'b1));
        if (did != 2'b00) tb_rr = !tb_rr;
        hold = rv && !bus.res_ready;
        hold_val = {1'b1, bus.res_id, bus.res_flags, bus.res_data};
      end
    end
  end

  task automatic rst_pulse();
    @(posedge clk); #1;
    reset = 1'b1; set_port(0, 1'b0, '0, '0); set_port(1, 1'b0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_one(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [34:0] exp, input string nm);
    logic ok = 1'b0;
    @(posedge clk); #1;
    bus.res_ready = 1'b1; set_port(p, 1'b1, a, b);
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; ok = did[p]; end
    set_port(p, 1'b0, '0, '0);
    chk({nm, " transfer"}, ok, 1);
    chk({nm, " early"}, bus.res_valid, 0);
    @(posedge clk); #1;
    chk({nm, " valid"}, bus.res_valid, 1);
    chk(nm, {bus.res_id, bus.res_flags, bus.res_data}, {1'(p), exp});
  endtask

  task automatic stall_fill();
    int n = 0;
    logic [31:0] d1 = '0;
    rst_pulse();
    bus.res_ready = 1'b0;
    set_port(0, 1'b1, rand_op(), rand_op()); set_port(1, 1'b1, rand_op(), rand_op());
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (did[p]) begin n++; set_port(p, 1'b1, rand_op(), rand_op()); end
      if (i == 1) d1 = bus.res_data;
    end
    chk("stall transfers", n, 2);
    chk("stall data", bus.res_data, d1);
    chk("stall valid", bus.res_valid, 1);
    chk("stall ready", {bus.req1_ready, bus.req0_ready}, 0);
  endtask

  task automatic rand_phase(input int cycles, input int pv, input int pr);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++)
        if (!get_v(p) || did[p]) begin
          if ($urandom_range(0, 99) < pv) set_port(p, 1'b1, rand_op(), rand_op());
          else set_port(p, 1'b0, '0, '0);
        end
      bus.res_ready = $urandom_range(0, 99) < pr;
    end
  endtask

  initial begin
    logic ok;
    reset = 1'b1; bus.res_ready = 1'b0;
    set_port(0, 1'b0, '0, '0); set_port(1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset valid", bus.res_valid, 0);
    chk("reset data", bus.res_data, 0);
    chk("reset id", bus.res_id, 0);
    chk("reset flags", bus.res_flags, 0);

    send_one(0, 32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000}, "1.5x2.0");
    send_one(1, 32'hC0000000, 32'h40400000, {3'b000, 32'hC0C00000}, "-2x3");
    send_one(0, 32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000}, "overflow");
    send_one(1, 32'h00800000, 32'h00800000, {3'b001, 32'h00000000}, "underflow");
    send_one(0, 32'h80000000, 32'h40000000, {3'b000, 32'h80000000}, "-0x2");
    send_one(1, 32'h7F800000, 32'h00000000, {3'b100, 32'h7FC00000}, "inf x 0");
    send_one(0, 32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000}, "-inf x 2");

    rst_pulse();
    bus.res_ready = 1'b1;
    set_port(0, 1'b1, rand_op(), rand_op()); set_port(1, 1'b1, rand_op(), rand_op());
    #1;
    chk("first grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("alternate", did, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i >= 1) chk("throughput", bus.res_valid, 1);
      for (int p = 0; p < 2; p++) if (did[p]) set_port(p, 1'b1, rand_op(), rand_op());
    end

    stall_fill();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (did[p]) set_port(p, 1'b0, '0, '0);
    end

    stall_fill();
    rst_pulse();
    chk("midreset valid", bus.res_valid, 0);
    chk("midreset data", bus.res_data, 0);
    chk("midreset flags id", {bus.res_flags, bus.res_id}, 0);
    bus.res_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; chk("no stale", bus.res_valid, 0); end

    set_port(0, 1'b1, rand_op(), rand_op());
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; ok = did[0]; end
    set_port(0, 1'b0, '0, '0);
    chk("rr setup", ok, 1);
    rst_pulse();
    set_port(0, 1'b1, rand_op(), rand_op()); set_port(1, 1'b1, rand_op(), rand_op());
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; ok = did != 2'b00; end
    chk("rr after reset", did, 2'b01);

    rand_phase(300, 90, 90);
    rand_phase(300, 70, 40);
    rand_phase(300, 50, 100);

    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (did[p]) set_port(p, 1'b0, '0, '0);
      bus.res_ready = 1'b1;
      ok = !get_v(0) && !get_v(1) && sb.size() == 0 && !bus.res_valid;
    end
    chk("drain", {ok, 32'(sb.size())}, {1'b1, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
